// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle sequencer: opcodes, ALU op codes, FSM states, instruction classes.
package multicycle_control_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_RTYPE = 3'b010;
  localparam logic [2:0] ALU_ITYPE = 3'b011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    CLS_R      = 3'd0,
    CLS_I      = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4
  } iclass_t;

endpackage

// File: rtl/multicycle_control_opcode_class_decoder.sv
// Combinational opcode -> {instruction class, legal} mapping for the supported RV32I subset.
module opcode_class_decoder
  import multicycle_control_pkg::*;
(
  input  logic [6:0] opcode,
  output iclass_t    iclass,
  output logic       legal
);

  // classify the opcode; anything outside the subset is flagged illegal
  always_comb begin
    iclass = CLS_R;
    legal  = 1'b1;
    case (opcode)
      OP_R:      iclass = CLS_R;
      OP_I:      iclass = CLS_I;
      OP_LOAD:   iclass = CLS_LOAD;
      OP_STORE:  iclass = CLS_STORE;
      OP_BRANCH: iclass = CLS_BRANCH;
      default: begin
        iclass = CLS_R;
        legal  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer with memory-ready timeout.
// Define MULTICYCLE_PERF_EN to enable the cycles/instret performance counters.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int PERF_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instruction,
  input  logic              mem_ready,
  output logic              ir_write,
  output logic              pc_write,
  output logic              branch,
  output logic              iord,
  output logic              memread,
  output logic              memwrite,
  output logic              memtoreg,
  output logic              alusrc,
  output logic              regwrite,
  output logic [2:0]        aluop,
  output logic              instr_done,
  output logic              illegal_instr,
  output logic              mem_error,
  output logic [PERF_W-1:0] instret,
  output logic [PERF_W-1:0] cycles
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 2);

  state_t           state_r, state_nxt_s;
  iclass_t          class_r, dec_class_s;
  logic             dec_legal_s;
  logic [CNT_W-1:0] tmo_cnt_r;
  logic             tmo_expired_s;
  logic             entry_s;
  logic             unused_instr_s;

  logic ir_write_s, pc_write_s, branch_s, iord_s, memread_s, memwrite_s;
  logic memtoreg_s, alusrc_s, regwrite_s, done_s, illegal_s, mem_error_s;
  logic [2:0] aluop_s;

  assign unused_instr_s = ^instruction[31:7];

  opcode_class_decoder u_dec (
    .opcode (instruction[6:0]),
    .iclass (dec_class_s),
    .legal  (dec_legal_s)
  );

  // A disabled timeout (0) never expires even though the counter keeps running
  assign tmo_expired_s = (TIMEOUT_CYCLES != 0) && (tmo_cnt_r == CNT_W'(TIMEOUT_CYCLES));

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // latch the decoded class once so later states do not depend on the opcode input
  always_ff @(posedge clk) begin
    if (reset) begin
      class_r <= CLS_R;
    end else if (state_r == S_DECODE) begin
      class_r <= dec_class_s;
    end else begin
      class_r <= class_r;
    end
  end

  // memory-wait counter, cleared on every state entry (including timeout re-entry of FETCH)
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_r <= '0;
    end else if (entry_s) begin
      tmo_cnt_r <= '0;
    end else if ((state_r == S_FETCH) || (state_r == S_MEM)) begin
      tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end

  // next-state and control decode; memory strobes are Mealy on mem_ready/timeout
  always_comb begin
    state_nxt_s = state_r;
    entry_s     = 1'b0;
    ir_write_s  = 1'b0;
    pc_write_s  = 1'b0;
    branch_s    = 1'b0;
    iord_s      = 1'b0;
    memread_s   = 1'b0;
    memwrite_s  = 1'b0;
    memtoreg_s  = 1'b0;
    alusrc_s    = 1'b0;
    regwrite_s  = 1'b0;
    aluop_s     = ALU_ADD;
    done_s      = 1'b0;
    illegal_s   = 1'b0;
    mem_error_s = 1'b0;
    case (state_r)
      S_FETCH: begin
        memread_s = 1'b1;
        if (mem_ready) begin
          ir_write_s  = 1'b1;
          pc_write_s  = 1'b1;
          state_nxt_s = S_DECODE;
          entry_s     = 1'b1;
        end else if (tmo_expired_s) begin
          memread_s   = 1'b0;
          mem_error_s = 1'b1;
          state_nxt_s = S_FETCH;
          entry_s     = 1'b1;
        end else begin
          state_nxt_s = S_FETCH;
        end
      end
      S_DECODE: begin
        entry_s = 1'b1;
        if (dec_legal_s) begin
          state_nxt_s = S_EXEC;
        end else begin
          illegal_s   = 1'b1;
          state_nxt_s = S_FETCH;
        end
      end
      S_EXEC: begin
        entry_s = 1'b1;
        case (class_r)
          CLS_R: begin
            aluop_s     = ALU_RTYPE;
            state_nxt_s = S_WB;
          end
          CLS_I: begin
            aluop_s     = ALU_ITYPE;
            alusrc_s    = 1'b1;
            state_nxt_s = S_WB;
          end
          CLS_LOAD, CLS_STORE: begin
            aluop_s     = ALU_ADD;
            alusrc_s    = 1'b1;
            state_nxt_s = S_MEM;
          end
          CLS_BRANCH: begin
            aluop_s     = ALU_SUB;
            branch_s    = 1'b1;
            done_s      = 1'b1;
            state_nxt_s = S_FETCH;
          end
          default: begin
            state_nxt_s = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        iord_s     = 1'b1;
        alusrc_s   = 1'b1;
        aluop_s    = ALU_ADD;
        memread_s  = (class_r == CLS_LOAD);
        memwrite_s = (class_r != CLS_LOAD);
        if (mem_ready) begin
          entry_s = 1'b1;
          if (class_r == CLS_LOAD) begin
            state_nxt_s = S_WB;
          end else begin
            done_s      = 1'b1;
            state_nxt_s = S_FETCH;
          end
        end else if (tmo_expired_s) begin
          memread_s   = 1'b0;
          memwrite_s  = 1'b0;
          mem_error_s = 1'b1;
          state_nxt_s = S_FETCH;
          entry_s     = 1'b1;
        end else begin
          state_nxt_s = S_MEM;
        end
      end
      S_WB: begin
        regwrite_s  = 1'b1;
        memtoreg_s  = (class_r == CLS_LOAD);
        done_s      = 1'b1;
        state_nxt_s = S_FETCH;
        entry_s     = 1'b1;
      end
      default: begin
        state_nxt_s = S_FETCH;
        entry_s     = 1'b1;
      end
    endcase
  end

  // Reset silences every strobe immediately so an abandoned instruction emits nothing
  assign ir_write      = ir_write_s  & ~reset;
  assign pc_write      = pc_write_s  & ~reset;
  assign branch        = branch_s    & ~reset;
  assign iord          = iord_s      & ~reset;
  assign memread       = memread_s   & ~reset;
  assign memwrite      = memwrite_s  & ~reset;
  assign memtoreg      = memtoreg_s  & ~reset;
  assign alusrc        = alusrc_s    & ~reset;
  assign regwrite      = regwrite_s  & ~reset;
  assign aluop         = aluop_s & {3{~reset}};
  assign instr_done    = done_s      & ~reset;
  assign illegal_instr = illegal_s   & ~reset;
  assign mem_error     = mem_error_s & ~reset;

`ifdef MULTICYCLE_PERF_EN
  logic [PERF_W-1:0] cycles_r, instret_r;

  // free-running performance counters, wrapping at 2^PERF_W
  always_ff @(posedge clk) begin
    if (reset) begin
      cycles_r  <= '0;
      instret_r <= '0;
    end else begin
      cycles_r <= cycles_r + PERF_W'(1);
      if (done_s) begin
        instret_r <= instret_r + PERF_W'(1);
      end else begin
        instret_r <= instret_r;
      end
    end
  end

  assign cycles  = cycles_r;
  assign instret = instret_r;
`else
  assign cycles  = {PERF_W{1'b0}};
  assign instret = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: per-instruction expected cycle script derived from the sequencing rules.
module tb_multicycle_control;

  localparam int T      = 4;
  localparam int PERF_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [31:0]       instruction = 32'h0;
  logic              mem_ready = 1'b0;
  logic              ir_write, pc_write, branch, iord, memread, memwrite;
  logic              memtoreg, alusrc, regwrite, instr_done, illegal_instr, mem_error;
  logic [2:0]        aluop;
  logic [PERF_W-1:0] instret, cycles;

  int errs = 0;
  int checks = 0;
  int cyc_m = 0;
  int ret_m = 0;

  multicycle_control #(.TIMEOUT_CYCLES(T), .PERF_W(PERF_W)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .mem_ready(mem_ready),
    .ir_write(ir_write), .pc_write(pc_write), .branch(branch), .iord(iord),
    .memread(memread), .memwrite(memwrite), .memtoreg(memtoreg), .alusrc(alusrc),
    .regwrite(regwrite), .aluop(aluop), .instr_done(instr_done),
    .illegal_instr(illegal_instr), .mem_error(mem_error),
    .instret(instret), .cycles(cycles)
  );

  always #5 clk = ~clk;

  // packed output view: ir pc br iord mrd mwr mtr asrc rw aluop[2:0] done ill merr
  logic [14:0] outv;
  assign outv = {ir_write, pc_write, branch, iord, memread, memwrite, memtoreg,
                 alusrc, regwrite, aluop, instr_done, illegal_instr, mem_error};

  localparam logic [14:0] IRW  = 15'h4000, PCW = 15'h2000, BR  = 15'h1000, IORD = 15'h0800;
  localparam logic [14:0] MRD  = 15'h0400, MWR = 15'h0200, MTR = 15'h0100, ASRC = 15'h0080;
  localparam logic [14:0] RW   = 15'h0040, DONE = 15'h0004, ILL = 15'h0002, MERR = 15'h0001;

  function automatic logic [14:0] aop(input logic [2:0] a);
    return {9'b0, a, 3'b0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [PERF_W-1:0] perf_exp(input int v);
`ifdef MULTICYCLE_PERF_EN
    return PERF_W'(v);
`else
    return {PERF_W{1'b0}};
`endif
  endfunction

  // one clock cycle: drive mem_ready, check outputs and counters, advance the model
  task automatic cyc(input logic mr, input logic [14:0] expv, input string tag);
    mem_ready = mr;
    #1;
    chk(tag, 64'(outv), 64'(expv));
    chk({tag, ".cycles"}, 64'(cycles), 64'(perf_exp(cyc_m)));
    chk({tag, ".instret"}, 64'(instret), 64'(perf_exp(ret_m)));
    cyc_m++;
    if ((expv & DONE) != 15'h0) ret_m++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = $urandom_range(0, 1);
    #1;
    chk("reset.out0", 64'(outv), 64'h0);
    @(negedge clk);
    #1;
    chk("reset.out1", 64'(outv), 64'h0);
    chk("reset.cycles", 64'(cycles), 64'h0);
    chk("reset.instret", 64'(instret), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    cyc_m = 0;
    ret_m = 0;
  endtask

  // fw/mw: mem_ready-low cycles before ready in FETCH/MEMORY (> T means timeout)
  // stop_mem >= 0: leave the instruction after that many MEMORY cycles
  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input int stop_mem);
    int cls;
    logic ld;
    logic [14:0] base;
    instruction = ins;
    case (ins[6:0])
      7'h33: cls = 0;
      7'h13: cls = 1;
      7'h03: cls = 2;
      7'h23: cls = 3;
      7'h63: cls = 4;
      default: cls = -1;
    endcase
    ld = (cls == 2);
    for (int k = 0; ; k++) begin
      if (k == fw) begin
        cyc(1'b1, IRW | PCW | MRD, "fetch.ready");
        break;
      end else if (k == T) begin
        cyc(1'b0, MERR, "fetch.timeout");
        return;
      end else begin
        cyc(1'b0, MRD, "fetch.wait");
      end
    end
    if (cls < 0) begin
      cyc($urandom_range(0, 1), ILL, "decode.illegal");
      return;
    end
    cyc($urandom_range(0, 1), 15'h0, "decode");
    case (cls)
      0: cyc($urandom_range(0, 1), aop(3'b010), "exec.r");
      1: cyc($urandom_range(0, 1), aop(3'b011) | ASRC, "exec.i");
      4: begin
        cyc($urandom_range(0, 1), aop(3'b001) | BR | DONE, "exec.branch");
        return;
      end
      default: cyc($urandom_range(0, 1), aop(3'b000) | ASRC, "exec.ldst");
    endcase
    if (cls == 2 || cls == 3) begin
      base = IORD | ASRC;
      for (int k = 0; ; k++) begin
        if (stop_mem >= 0 && k == stop_mem) return;
        if (k == mw) begin
          cyc(1'b1, base | (ld ? MRD : (MWR | DONE)), "mem.ready");
          break;
        end else if (k == T) begin
          cyc(1'b0, base | MERR, "mem.timeout");
          return;
        end else begin
          cyc(1'b0, base | (ld ? MRD : MWR), "mem.wait");
        end
      end
      if (!ld) return;
    end
    cyc($urandom_range(0, 1), RW | (ld ? MTR : 15'h0) | DONE, "wb");
  endtask

  initial begin
    logic [31:0] r;
    logic [6:0]  op;
    int          pick;
    @(negedge clk);
    do_reset();
    run_instr(32'h00000033, 0, 0, -1);
    chk("r.instret", 64'(instret), 64'(perf_exp(1)));
    run_instr(32'h00000003, 0, 2, -1);
    run_instr(32'h00000023, 0, 0, -1);
    run_instr(32'h00000063, 0, 0, -1);
    run_instr(32'h00000067, 0, 0, -1);
    run_instr(32'h00000013, 0, 0, -1);
    run_instr(32'h00000033, 7, 0, -1);
    run_instr(32'h00000033, T, 0, -1);
    run_instr(32'h00000023, 0, 7, -1);
    run_instr(32'h00000003, 0, T, -1);
    run_instr(32'h00000003, 1, 9, 1);
    do_reset();
    run_instr(32'h00000013, 0, 0, -1);
    for (int n = 0; n < 120; n++) begin
      r = $urandom();
      pick = $urandom_range(0, 5);
      case (pick)
        0: op = 7'h33;
        1: op = 7'h13;
        2: op = 7'h03;
        3: op = 7'h23;
        4: op = 7'h63;
        default: begin
          op = 7'($urandom());
          if (op == 7'h33 || op == 7'h13 || op == 7'h03 || op == 7'h23 || op == 7'h63)
            op = 7'h67;
        end
      endcase
      run_instr({r[31:7], op}, $urandom_range(0, T + 1), $urandom_range(0, T + 1), -1);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multicycle sequencer for the RV32I-subset datapath. It replaces the one-shot opcode decode with an FSM that drives Fetch, Decode, Execute, Memory and Writeback over successive cycles. It handshakes with a shared instruction/data memory through mem_ready. It produces the same control signal set as the single-cycle decoder, plus ir_write, pc_write, iord and a retire pulse.

Parameters:
TIMEOUT_CYCLES, 16, max cycles to wait for mem_ready in FETCH/MEMORY; 0 disables timeout
PERF_W, 32, width of the optional performance counters

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
instruction  input  32  instruction register contents; opcode = instruction[6:0]
mem_ready  input  1  memory completes the current read/write this cycle
ir_write  output  1  load instruction register
pc_write  output  1  unconditional PC update (PC+4)
branch  output  1  conditional PC update if ALU zero
iord  output  1  0 = memory address from PC, 1 = from ALU result
memread  output  1  memory read request
memwrite  output  1  memory write request
memtoreg  output  1  writeback data from memory (1) or ALU (0)
alusrc  output  1  ALU B operand = immediate
regwrite  output  1  register file write enable
aluop  output  3  000 add, 001 sub, 010 R-type funct, 011 I-type funct
instr_done  output  1  one-cycle pulse when an instruction retires
illegal_instr  output  1  one-cycle pulse on an unsupported opcode
mem_error  output  1  one-cycle pulse on memory timeout
instret  output  PERF_W  retired-instruction count (optional feature)
cycles  output  PERF_W  cycles since reset (optional feature)

Behaviour:
- Reset: state=FETCH, every output 0, timeout counter 0. Reset mid-instruction abandons the instruction with no pulse.
- Supported opcodes: R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011. Decode them once in DECODE and register the class.
- Outputs not listed in a state are 0.
- FETCH: memread=1, iord=0.
  - mem_ready=1: ir_write=1 and pc_write=1 in the same cycle (Mealy); next state DECODE.
  - mem_ready=0: stay; timeout counter increments.
- DECODE: one cycle, no strobes. Legal opcode -> EXECUTE. Illegal opcode -> illegal_instr=1 this cycle, next FETCH, no retire.
- EXECUTE:
  - R: aluop=010, alusrc=0, next WRITEBACK.
  - I: aluop=011, alusrc=1, next WRITEBACK.
  - LOAD/STORE: aluop=000, alusrc=1, next MEMORY.
  - BRANCH: aluop=001, alusrc=0, branch=1, instr_done=1, next FETCH.
- MEMORY: iord=1, aluop=000, alusrc=1. LOAD drives memread=1; STORE drives memwrite=1.
  - mem_ready=1: LOAD -> WRITEBACK; STORE -> instr_done=1, next FETCH.
  - mem_ready=0: stay.
- WRITEBACK: regwrite=1; memtoreg=1 for LOAD, 0 otherwise; instr_done=1; next FETCH.
- Timeout counter:
  - Clears on every state entry.
  - Reaching TIMEOUT_CYCLES in FETCH or MEMORY with mem_ready still 0: mem_error=1, memread/memwrite deassert that cycle, next FETCH, no retire.
  - mem_ready arriving in the same cycle the count expires wins: normal completion, no error.
- Latency with mem_ready tied 1: BRANCH 3 cycles, R/I/STORE 4, LOAD 5. Each memory wait cycle adds 1.

Optional Feature:
MULTICYCLE_PERF_EN
- Defined: `cycles` increments every non-reset cycle. `instret` increments on each instr_done. Both wrap modulo 2^PERF_W and clear on reset.
- Undefined: both ports tied to 0, no counter flops.

Decomposition:
- Shared include file control_defs.vh holds:
  - opcode constants: OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH;
  - aluop codes: ALU_ADD, ALU_SUB, ALU_RTYPE, ALU_ITYPE;
  - FSM state encodings: S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB.
- One natural sub-module: opcode_class_decoder, a combinational opcode to {class, legal} mapping. FSM, timeout and counters stay in multicycle_control.

Test Plan:
- Reset held 2 cycles, then instruction=0x00000033 with mem_ready=1 -> ir_write/pc_write in cycle 0, aluop=010 in cycle 2, regwrite=1 and instr_done=1 in cycle 3; instret=1.
- LOAD 0x00000003, mem_ready low for 2 cycles in MEMORY -> memread=1, iord=1 for 3 cycles; then regwrite=1, memtoreg=1; 7 cycles total.
- STORE 0x00000023 -> memwrite=1 in MEMORY; regwrite never asserted; instr_done in cycle 3. BRANCH 0x00000063 -> branch=1, aluop=001 in cycle 2, instr_done in the same cycle.
- Opcode 0x00000067 -> illegal_instr pulse in DECODE; next cycle FETCH; instret unchanged.
- TIMEOUT_CYCLES=4, mem_ready stuck 0 in FETCH -> mem_error pulses in cycle 4, then FETCH restarts. mem_ready rising in the expiry cycle -> no mem_error.
- Reset asserted during MEMORY of a LOAD -> next cycle all outputs 0, state FETCH, no instr_done, counters 0.
